// File: rtl/rv32_fetch_alu_core.sv
// RV32 fetch/execute slice: program counter with +4 incrementer, word-organised
// instruction memory with a program-load port, and a combinational integer ALU.
module rv32_fetch_alu_core #(
  parameter int N = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instrre,
  input  logic        pcnextctl,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluop,
  output logic [31:0] pc,
  output logic [31:0] pcadd4,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [1:0]  func7b50,
  output logic [31:0] alures,
  output logic        aluzero
);

  localparam int          AW  = $clog2(N);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   mem_q [N];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [4:0]    shamt;
  logic          unused_waddr_bits;

  // Word index only; upper address bits alias and byte offset is dropped.
  assign rd_idx = pc_q[AW+1:2];
  assign wr_idx = imem_waddr[AW+1:2];
  assign unused_waddr_bits = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

  assign pcadd4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (pcnextctl) pc_d = pcadd4;
    if (instrre)   instr_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Program load keeps working through reset; the read above sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we) mem_q[wr_idx] <= imem_wdata;
  end

  assign pc       = pc_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[6:0];
  assign func3    = instr_q[14:12];
  assign func7b50 = {instr_q[30], instr_q[25]};

  assign shamt = b[4:0];

  always_comb begin
    alures = 32'h0000_0000;
    case (aluop)
      4'b0000: alures = a + b;
      4'b1000: alures = a + ~b + 32'd1;
      4'b0001: alures = a << shamt;
      4'b0010: alures = {31'd0, $signed(a) < $signed(b)};
      4'b0011: alures = {31'd0, a < b};
      4'b0100: alures = a ^ b;
      4'b0101: alures = a >> shamt;
      4'b1101: alures = $unsigned($signed(a) >>> shamt);
      4'b0110: alures = a | b;
      4'b0111: alures = a & b;
      default: alures = 32'h0000_0000;
    endcase
  end

  assign aluzero = (alures == 32'h0000_0000);

endmodule

// File: tb/tb_rv32_fetch_alu_core.sv
// Directed self-checking bench for rv32_fetch_alu_core, built with a 4-word
// memory so address aliasing is reachable in a handful of cycles.
module tb_rv32_fetch_alu_core;

  logic        clk;
  logic        rst;
  logic        instrre;
  logic        pcnextctl;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluop;
  logic [31:0] pc;
  logic [31:0] pcadd4;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [1:0]  func7b50;
  logic [31:0] alures;
  logic        aluzero;

  int n_cmp;
  int n_bad;

  rv32_fetch_alu_core #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instrre    (instrre),
    .pcnextctl  (pcnextctl),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .a          (a),
    .b          (b),
    .aluop      (aluop),
    .pc         (pc),
    .pcadd4     (pcadd4),
    .instr      (instr),
    .opcode     (opcode),
    .func3      (func3),
    .func7b50   (func7b50),
    .alures     (alures),
    .aluzero    (aluzero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instrre   = 1'b0;
    pcnextctl = 1'b0;
    imem_we   = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    instrre   = 1'b1;
    pcnextctl = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_cmp++; if (instr !== 32'h13) begin n_bad++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h13); end
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_overrides_adv: got %h expected %h", pc, 32'h0); end
    instrre   = 1'b0;
    pcnextctl = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (pcadd4 !== 32'h4) begin n_bad++; $display("FAIL reset_pcadd4: got %h expected %h", pcadd4, 32'h4); end
    n_cmp++; if (opcode !== 7'h13) begin n_bad++; $display("FAIL reset_opcode: got %h expected %h", opcode, 7'h13); end
    n_cmp++; if (func3 !== 3'd0) begin n_bad++; $display("FAIL reset_func3: got %h expected %h", func3, 3'd0); end
    n_cmp++; if (func7b50 !== 2'd0) begin n_bad++; $display("FAIL reset_func7b50: got %h expected %h", func7b50, 2'd0); end
  endtask

  task automatic test_increment();
    do_reset();
    pcnextctl = 1'b1;
    repeat (3) tick();
    pcnextctl = 1'b0;
    n_cmp++; if (pc !== 32'hC) begin n_bad++; $display("FAIL inc_pc: got %h expected %h", pc, 32'hC); end
    n_cmp++; if (pcadd4 !== 32'h10) begin n_bad++; $display("FAIL inc_pcadd4: got %h expected %h", pcadd4, 32'h10); end
    tick();
    n_cmp++; if (pc !== 32'hC) begin n_bad++; $display("FAIL inc_hold: got %h expected %h", pc, 32'hC); end
  endtask

  task automatic test_load_fetch();
    do_reset();
    write_word(32'h0000_0000, 32'h0020_81B3);
    write_word(32'h0000_0006, 32'h4020_8233);  // byte offset bits must be ignored
    instrre = 1'b1;
    tick();
    instrre = 1'b0;
    n_cmp++; if (instr !== 32'h0020_81B3) begin n_bad++; $display("FAIL fetch0_instr: got %h expected %h", instr, 32'h0020_81B3); end
    n_cmp++; if (opcode !== 7'h33) begin n_bad++; $display("FAIL fetch0_opcode: got %h expected %h", opcode, 7'h33); end
    n_cmp++; if (func3 !== 3'd0) begin n_bad++; $display("FAIL fetch0_func3: got %h expected %h", func3, 3'd0); end
    n_cmp++; if (func7b50 !== 2'b00) begin n_bad++; $display("FAIL fetch0_func7b50: got %b expected %b", func7b50, 2'b00); end
    pcnextctl = 1'b1;
    tick();
    pcnextctl = 1'b0;
    instrre   = 1'b1;
    tick();
    instrre = 1'b0;
    n_cmp++; if (instr !== 32'h4020_8233) begin n_bad++; $display("FAIL fetch1_instr: got %h expected %h", instr, 32'h4020_8233); end
    n_cmp++; if (func7b50 !== 2'b10) begin n_bad++; $display("FAIL fetch1_func7b50: got %b expected %b", func7b50, 2'b10); end
  endtask

  task automatic test_fetch_advance_hold();
    do_reset();
    instrre   = 1'b1;
    pcnextctl = 1'b1;
    tick();
    instrre   = 1'b0;
    pcnextctl = 1'b0;
    n_cmp++; if (instr !== 32'h0020_81B3) begin n_bad++; $display("FAIL fadv_instr: got %h expected %h", instr, 32'h0020_81B3); end
    n_cmp++; if (pc !== 32'h4) begin n_bad++; $display("FAIL fadv_pc: got %h expected %h", pc, 32'h4); end
    tick();
    tick();
    n_cmp++; if (instr !== 32'h0020_81B3) begin n_bad++; $display("FAIL fhold_instr: got %h expected %h", instr, 32'h0020_81B3); end
  endtask

  task automatic test_reset_mid_op();
    instrre   = 1'b1;
    pcnextctl = 1'b1;
    imem_we   = 1'b1;
    imem_waddr = 32'h0000_0008;
    imem_wdata = 32'h1234_5678;
    rst = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rstmid_pc: got %h expected %h", pc, 32'h0); end
    n_cmp++; if (instr !== 32'h13) begin n_bad++; $display("FAIL rstmid_instr: got %h expected %h", instr, 32'h13); end
    imem_we = 1'b0;
    instrre = 1'b0;
    rst = 1'b0;
    pcnextctl = 1'b1;
    tick();
    tick();
    pcnextctl = 1'b0;
    instrre   = 1'b1;
    tick();
    instrre = 1'b0;
    n_cmp++; if (instr !== 32'h1234_5678) begin n_bad++; $display("FAIL rstmid_write: got %h expected %h", instr, 32'h1234_5678); end
  endtask

  task automatic test_alu_arith();
    logic [3:0]  ops [8]  = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0010, 4'b0011, 4'b0010, 4'b0011};
    logic [31:0] av  [8]  = '{32'hFFFF_FFFF, 32'd5, 32'd5, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1};
    logic [31:0] bv  [8]  = '{32'd1, 32'd7, 32'd7, 32'd7, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ev  [8]  = '{32'h0, 32'd12, 32'hFFFF_FFFE, 32'h0, 32'd1, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 8; i++) begin
      aluop = ops[i];
      a = av[i];
      b = bv[i];
      #1;
      n_cmp++; if (alures !== ev[i]) begin n_bad++; $display("FAIL alu_arith[%0d] op=%b: got %h expected %h", i, ops[i], alures, ev[i]); end
      n_cmp++; if (aluzero !== (ev[i] == 32'h0)) begin n_bad++; $display("FAIL alu_arith_zero[%0d]: got %b expected %b", i, aluzero, ev[i] == 32'h0); end
    end
  endtask

  task automatic test_alu_shift_logic();
    logic [3:0]  ops [9] = '{4'b1101, 4'b0101, 4'b0001, 4'b0101, 4'b0111, 4'b0110, 4'b0100, 4'b1111, 4'b1001};
    logic [31:0] av  [9] = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] bv  [9] = '{32'd4, 32'd4, 32'd33, 32'd36, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] ev  [9] = '{32'hF800_0000, 32'h0800_0000, 32'd2, 32'h0800_0000, 32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      aluop = ops[i];
      a = av[i];
      b = bv[i];
      #1;
      n_cmp++; if (alures !== ev[i]) begin n_bad++; $display("FAIL alu_shlog[%0d] op=%b: got %h expected %h", i, ops[i], alures, ev[i]); end
      n_cmp++; if (aluzero !== (ev[i] == 32'h0)) begin n_bad++; $display("FAIL alu_shlog_zero[%0d]: got %b expected %b", i, aluzero, ev[i] == 32'h0); end
    end
  endtask

  task automatic test_wrap_alias();
    do_reset();
    pcnextctl = 1'b1;
    repeat (4) tick();
    pcnextctl = 1'b0;
    n_cmp++; if (pc !== 32'h10) begin n_bad++; $display("FAIL alias_pc: got %h expected %h", pc, 32'h10); end
    instrre = 1'b1;
    tick();
    n_cmp++; if (instr !== 32'h0020_81B3) begin n_bad++; $display("FAIL alias_fetch: got %h expected %h", instr, 32'h0020_81B3); end
    // Fetch and overwrite the same word on one edge: old data comes back.
    imem_we    = 1'b1;
    imem_waddr = 32'h0000_0000;
    imem_wdata = 32'hDEAD_BEEF;
    instrre    = 1'b1;
    tick();
    imem_we = 1'b0;
    n_cmp++; if (instr !== 32'h0020_81B3) begin n_bad++; $display("FAIL rdfirst_old: got %h expected %h", instr, 32'h0020_81B3); end
    tick();
    instrre = 1'b0;
    n_cmp++; if (instr !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rdfirst_new: got %h expected %h", instr, 32'hDEAD_BEEF); end
    // The top of the address space is out of reach by stepping; park the PC there.
    @(negedge clk);
    force dut.pc_q = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (pcadd4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pcadd4: got %h expected %h", pcadd4, 32'h0); end
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc_top: got %h expected %h", pc, 32'hFFFF_FFFC); end
    release dut.pc_q;
    do_reset();
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap_recover: got %h expected %h", pc, 32'h0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    instrre    = 1'b0;
    pcnextctl  = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = 32'h0;
    imem_wdata = 32'h0;
    a          = 32'h0;
    b          = 32'h0;
    aluop      = 4'b0000;
    tick();
    rst = 1'b0;
    #1;

    test_reset();
    test_increment();
    test_load_fetch();
    test_fetch_advance_hold();
    test_reset_mid_op();
    test_alu_arith();
    test_alu_shift_logic();
    test_wrap_alias();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
